// File: rtl/alu_result_tx.sv
// alu_result_tx: serialises a signed ALU result as an 8-bit UART-style frame.
// The frame is a start bit (0), then 8 data bits sent LSB first, then a stop bit (1).
// Each bit lasts CLK_DIV clock cycles.
// The result is sign-extended to 8 bits when it is captured.
// Optional feature: define ALU_RESULT_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit.
module alu_result_tx #(
  parameter int NB_AB   = 6,
  parameter int CLK_DIV = 16
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_AB-1:0] i_result,
  input  logic             i_send,
  output logic             o_tx,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

`ifdef ALU_RESULT_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic signed [NB_AB-1:0] result_s;
  logic [7:0]              result_ext;
  logic                    tick;

  // A size cast of a signed operand sign-extends, which turns the result into a byte.
  assign result_s   = i_result;
  assign result_ext = 8'(result_s);
  assign tick       = (cnt_q == CNT_LAST);

  // Next-state logic, bit timing and the registered output values.
  always_comb begin
    // NOTE: every signal gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_send) begin
          data_d    = result_ext;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = START;
        end
      end
      START: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
`ifdef ALU_RESULT_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef ALU_RESULT_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (tick) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The outputs are decoded from the next state, so their flops line up with the state register.
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_idx_d];
`ifdef ALU_RESULT_TX_PARITY_EN
      PARITY:  tx_d = ^data_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State and output registers, with a synchronous reset that overrides any request.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (i_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      data_q    <= 8'd0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Testbench for alu_result_tx with CLK_DIV=16 and NB_AB=6.
// It follows ALU_RESULT_TX_PARITY_EN to decide whether frames carry a parity bit.
module tb_alu_result_tx;

  localparam int NB  = 6;
  localparam int DIV = 16;
`ifdef ALU_RESULT_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif

  logic          clock = 1'b0;
  logic          i_reset;
  logic          i_send;
  logic [NB-1:0] i_result;
  logic          o_tx, o_busy, o_done;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  alu_result_tx #(.NB_AB(NB), .CLK_DIV(DIV)) dut (
    .clock    (clock),
    .i_reset  (i_reset),
    .i_result (i_result),
    .i_send   (i_send),
    .o_tx     (o_tx),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // Reference model: the value is read as a signed integer and then rewritten as an 8-bit two's-complement byte.
  function automatic logic [7:0] model_data(input int v);
    int s;
    s = (v >= (1 << (NB - 1))) ? v - (1 << NB) : v;
    return 8'((s + 256) % 256);
  endfunction

  function automatic logic model_parity(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return (ones % 2) == 1;
  endfunction

  // Sends one frame and checks o_tx and o_busy over every bit slot, then checks the o_done cycle.
  // hold keeps i_send high through the frame and the done cycle.
  // glitch_cyc re-pulses i_send with a different value in that frame cycle.
  task automatic send_and_check(input string tag, input logic [NB-1:0] val,
                                input logic [7:0] data, input logic par,
                                input int glitch_cyc, input bit hold, input bit pre_driven);
    logic [31:0] tx_vec, busy_vec, exp_vec, mask;
    logic        exp_bit;
    int          done_seen, cyc;
    mask = (32'd1 << DIV) - 32'd1;
    if (!pre_driven) begin
      @(negedge clock);
      i_result = val;
      i_send   = 1'b1;
    end
    done_seen = 0;
    for (int s = 0; s < NSLOT; s++) begin
      tx_vec   = '0;
      busy_vec = '0;
      if (s == 0)                    exp_bit = 1'b0;
      else if (s <= 8)               exp_bit = data[s-1];
      else if (NSLOT == 11 && s == 9) exp_bit = par;
      else                           exp_bit = 1'b1;
      for (int c = 0; c < DIV; c++) begin
        @(negedge clock);
        tx_vec[c]   = o_tx;
        busy_vec[c] = o_busy;
        if (o_done) done_seen++;
        cyc = s * DIV + c + 1;
        if (hold) begin
          i_send   = 1'b1;
          i_result = val;
        end else if (cyc == glitch_cyc) begin
          i_send   = 1'b1;
          i_result = ~val;
        end else begin
          i_send   = 1'b0;
          i_result = NB'($urandom);
        end
      end
      exp_vec = exp_bit ? mask : 32'd0;
      check($sformatf("%s tx slot %0d", tag, s), tx_vec, exp_vec);
      check($sformatf("%s busy slot %0d", tag, s), busy_vec, mask);
    end
    check({tag, " no done inside frame"}, done_seen, 0);
    @(negedge clock);
    check({tag, " done cycle {tx,busy,done}"}, {o_tx, o_busy, o_done}, 3'b101);
    i_send = hold;
    if (!hold) begin
      @(negedge clock);
      check({tag, " idle after done {tx,busy,done}"}, {o_tx, o_busy, o_done}, 3'b100);
    end
  endtask

  typedef struct {
    logic [NB-1:0] val;
    logic [7:0]    data;
    logic          par;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int v, done_cnt, busy_cnt;
    logic [7:0] d;

    tbl[0] = '{6'b000101, 8'h05, 1'b0};
    tbl[1] = '{6'b111110, 8'hFE, 1'b1};
    tbl[2] = '{6'd7,      8'h07, 1'b1};
    tbl[3] = '{6'd3,      8'h03, 1'b0};
    tbl[4] = '{6'h20,     8'hE0, 1'b1};
    tbl[5] = '{6'h1F,     8'h1F, 1'b1};
    tbl[6] = '{6'h00,     8'h00, 1'b0};

    i_reset  = 1'b1;
    i_send   = 1'b0;
    i_result = '0;
    repeat (3) @(negedge clock);
    check("reset state {tx,busy,done}", {o_tx, o_busy, o_done}, 3'b100);
    i_reset = 1'b0;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 7; i++)
      send_and_check($sformatf("table[%0d]", i), tbl[i].val, tbl[i].data, tbl[i].par, 0, 1'b0, 1'b0);

    // Re-request in cycle 50 of a frame: the frame must not change and no second frame may follow.
    send_and_check("resend@50", 6'b000101, 8'h05, 1'b0, 50, 1'b0, 1'b0);

    // Hold i_send high: the second frame must start straight after the done cycle.
    send_and_check("b2b first", 6'd7, 8'h07, 1'b1, 0, 1'b1, 1'b0);
    send_and_check("b2b second", 6'd7, 8'h07, 1'b1, 0, 1'b0, 1'b1);

    // Reset in cycle 70 of a frame: the frame is aborted without a done pulse.
    @(negedge clock);
    i_result = 6'b000101;
    i_send   = 1'b1;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(negedge clock);
      i_send = 1'b0;
      if (cyc == 70) i_reset = 1'b1;
    end
    @(negedge clock);
    check("reset mid-frame {tx,busy,done}", {o_tx, o_busy, o_done}, 3'b100);
    i_reset  = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      done_cnt += int'(o_done);
      busy_cnt += int'(o_busy);
    end
    check("no done after abort", done_cnt, 0);
    check("no busy after abort", busy_cnt, 0);

    // A reset together with a send request must win over the request.
    i_reset = 1'b1;
    i_send  = 1'b1;
    @(negedge clock);
    check("reset beats send {tx,busy,done}", {o_tx, o_busy, o_done}, 3'b100);
    i_reset = 1'b0;
    i_send  = 1'b0;
    @(negedge clock);
    send_and_check("post-reset", 6'b000101, 8'h05, 1'b0, 0, 1'b0, 1'b0);

    // Random values, checked against the reference model.
    for (int r = 0; r < 10; r++) begin
      v = int'($urandom_range(0, (1 << NB) - 1));
      d = model_data(v);
      send_and_check($sformatf("rand[%0d] v=%0d", r, v), NB'(v), d, model_parity(d),
                     (r % 2 == 1) ? int'($urandom_range(1, NSLOT * DIV)) : 0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
